// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the ram_arbiter slice
// Purpose: FSM state encoding and default geometry of the shared 4x1 RAM.
// Ports: none (package).
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 2;
  localparam int RAM_DATA_W = 1;
  localparam int NUM_WORDS  = 4;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin pick, combinational
// Purpose: choose one of two requesters, favouring the one not served last.
// Ports:
//   req0, req1 : requests
//   last       : index of the requester served most recently
//   grant      : one-hot pick, bit0 = requester 0, 2'b00 when idle
module rr_arbiter2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req0 && req1) begin
      grant = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin access sequencer for the 4x1 ram
// Purpose: shares one ram between two requesters, one access in flight, each
//   access sequenced SETUP/STROBE/HOLD/DONE so writes commit on wr falling.
// Optional: RAM_ARB_INIT_EN adds a power-up clear of all words (INIT state).
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   reqN/weN/addrN/wdataN     : requester N access, held until doneN
//   gntN, doneN, rdataN       : ownership, completion pulse, last read data
//   init_busy                 : power-up clear running
//   ram_a/ram_wr/ram_din/ram_rd/ram_dout : ram side
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              init_busy,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_dout
);

`ifdef RAM_ARB_INIT_EN
  localparam arb_state_t        RESET_STATE = INIT;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_WORDS - 1);
  // 0 = setup, 1 = strobe, 2 = hold for the word currently being cleared
  logic [1:0] init_phase;
`else
  localparam arb_state_t RESET_STATE = IDLE;
`endif

  arb_state_t        state, state_nxt;
  logic              ptr;       // requester served last
  logic              owner;     // requester owning the current access
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [1:0]        pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              wr_nxt, rd_nxt;
  logic              in_access;

  rr_arbiter2 u_rr (
    .req0  (req0),
    .req1  (req1),
    .last  (ptr),
    .grant (pick)
  );

  assign sel_we    = pick[1] ? we1    : we0;
  assign sel_addr  = pick[1] ? addr1  : addr0;
  assign sel_wdata = pick[1] ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: begin
`ifdef RAM_ARB_INIT_EN
        if (init_phase == 2'd2 && op_addr == LAST_ADDR) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      IDLE:    if (pick != 2'b00) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  state_nxt = HOLD;
      HOLD:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ram_wr and ram_rd are registered so the strobe the ram flops clock on
  // never glitches through state decode; they are computed one cycle early.
  always_comb begin
    wr_nxt = (state_nxt == STROBE) && op_we;
    rd_nxt = 1'b0;
    if (state == IDLE && pick != 2'b00) begin
      rd_nxt = !sel_we;
    end else if (state_nxt == STROBE || state_nxt == HOLD) begin
      rd_nxt = !op_we;
    end
`ifdef RAM_ARB_INIT_EN
    if (state == INIT && init_phase == 2'd0) wr_nxt = 1'b1;
`endif
  end

  always_comb begin
    in_access = (state == SETUP) || (state == STROBE) || (state == HOLD) || (state == DONE);
    gnt0      = in_access && !owner;
    gnt1      = in_access && owner;
    done0     = (state == DONE) && !owner;
    done1     = (state == DONE) && owner;
`ifdef RAM_ARB_INIT_EN
    init_busy = (state == INIT);
`else
    init_busy = 1'b0;
`endif
  end

  assign ram_a   = op_addr;
  assign ram_din = op_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b1;
      owner    <= 1'b0;
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
      ram_wr   <= 1'b0;
      ram_rd   <= 1'b0;
`ifdef RAM_ARB_INIT_EN
      init_phase <= 2'd0;
`endif
    end else begin
      ram_wr <= wr_nxt;
      ram_rd <= rd_nxt;
      case (state)
        IDLE: begin
          if (pick != 2'b00) begin
            owner    <= pick[1];
            op_we    <= sel_we;
            op_addr  <= sel_addr;
            op_wdata <= sel_wdata;
          end
        end
        HOLD: begin
          if (!op_we) begin
            if (owner) rdata1 <= ram_dout;
            else       rdata0 <= ram_dout;
          end
        end
        DONE: ptr <= owner;
`ifdef RAM_ARB_INIT_EN
        // op_wdata is 0 out of reset, so the clear writes zeros
        INIT: begin
          if (init_phase == 2'd2) begin
            init_phase <= 2'd0;
            op_addr    <= op_addr + ADDR_W'(1);
          end else begin
            init_phase <= init_phase + 2'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a ram model
module tb_ram_arbiter;

  typedef struct packed {
    logic       we;
    logic [1:0] addr;
    logic       data;
  } op_t;

`ifdef RAM_ARB_INIT_EN
  localparam logic EXP_INIT_BUSY = 1'b1;
`else
  localparam logic EXP_INIT_BUSY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1, wdata0, wdata1;
  logic [1:0] addr0, addr1;
  logic       gnt0, gnt1, done0, done1, rdata0, rdata1, init_busy;
  logic [1:0] ram_a;
  logic       ram_wr, ram_din, ram_rd, ram_dout;

  int n_checks = 0;
  int n_pass   = 0;

  logic       mem [4];
  logic       mdl [4];
  logic [1:0] exp_rd;
  op_t        q0[$];
  op_t        q1[$];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(2), .DATA_W(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .init_busy(init_busy),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_din(ram_din), .ram_rd(ram_rd),
    .ram_dout(ram_dout)
  );

  // ram model: storage captures on the falling edge of wr, read is combinational
  always @(negedge ram_wr) if (rst_n) mem[ram_a] = ram_din;
  assign ram_dout = mem[ram_a];

  // scoreboard: each done pops the op issued on that port
  always @(negedge clk) begin : scoreboard
    op_t op;
    if (rst_n && (done0 || done1)) begin
      n_checks++;
      if (done0 && done1) $display("FAIL done_overlap: got done0=1 done1=1 want only one");
      else n_pass++;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 && done0) || (p == 1 && done1)) begin
          n_checks++;
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            $display("FAIL sb_unexpected_done: port %0d got done want no done", p);
          end else begin
            n_pass++;
            if (p == 0) op = q0.pop_front();
            else        op = q1.pop_front();
            if (op.we) begin
              mdl[op.addr] = op.data;
              n_checks++;
              if (mem[op.addr] !== op.data)
                $display("FAIL sb_ram_word: addr %0d got %0b want %0b", op.addr, mem[op.addr], op.data);
              else n_pass++;
            end else begin
              exp_rd[p] = mdl[op.addr];
            end
          end
        end
      end
      n_checks++;
      if ({rdata1, rdata0} !== exp_rd)
        $display("FAIL sb_rdata: got %b want %b", {rdata1, rdata0}, exp_rd);
      else n_pass++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input int port, input logic we, input logic [1:0] a, input logic d);
    op_t op;
    op.we = we; op.addr = a; op.data = d;
    if (port == 0) begin
      we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; q0.push_back(op);
    end else begin
      we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; q1.push_back(op);
    end
  endtask

  task automatic wait_done(input int port, output int cyc, output int wr_cnt, output int first_gnt);
    logic seen;
    seen = 1'b0; cyc = 0; wr_cnt = 0; first_gnt = -1;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ram_wr) wr_cnt++;
      if (first_gnt < 0 && (port == 0 ? gnt0 : gnt1)) first_gnt = cyc;
      if (port == 0 ? done0 : done1) seen = 1'b1;
    end
    if (!seen) cyc = -1;
  endtask

  task automatic do_reset();
    int n;
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b0;
    q0.delete(); q1.delete(); exp_rd = '0;
`ifdef RAM_ARB_INIT_EN
    for (int i = 0; i < 4; i++) mdl[i] = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (init_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (init_busy !== 1'b0) $display("FAIL init_end: got init_busy=%0b want 0", init_busy);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({gnt0, gnt1, done0, done1, ram_wr, ram_rd, ram_din, rdata0, rdata1} !== 9'b0)
      $display("FAIL reset_outputs: got %b want 000000000",
               {gnt0, gnt1, done0, done1, ram_wr, ram_rd, ram_din, rdata0, rdata1});
    else n_pass++;
    n_checks++;
    if (ram_a !== 2'd0) $display("FAIL reset_ram_a: got %0d want 0", ram_a);
    else n_pass++;
    n_checks++;
    if (init_busy !== EXP_INIT_BUSY) $display("FAIL reset_init_busy: got %0b want %0b", init_busy, EXP_INIT_BUSY);
    else n_pass++;
    do_reset();
  endtask

`ifdef RAM_ARB_INIT_EN
  task automatic test_init();
    int n, k, cyc, wr, fg;
    logic [7:0] seq;
    logic gnt_early, busy;
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b0;
    q0.delete(); q1.delete(); exp_rd = '0;
    for (int i = 0; i < 4; i++) begin mem[i] = 1'b1; mdl[i] = 1'b0; end
    repeat (2) @(negedge clk);
    issue(0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    n = 1; k = 0; seq = '0; gnt_early = 1'b0; busy = 1'b1;
    while (busy && n < 40) begin
      @(negedge clk);
      if (!init_busy) busy = 1'b0;
      else begin
        n++;
        if (ram_wr) begin k++; seq = {ram_a, seq[7:2]}; end
        if (gnt0 || gnt1) gnt_early = 1'b1;
      end
    end
    n_checks++;
    if (n !== 12) $display("FAIL init_cycles: got %0d want 12", n); else n_pass++;
    n_checks++;
    if (k !== 4) $display("FAIL init_strobes: got %0d want 4", k); else n_pass++;
    n_checks++;
    if (seq !== 8'he4) $display("FAIL init_addr_seq: got %h want e4", seq); else n_pass++;
    n_checks++;
    if (gnt_early !== 1'b0) $display("FAIL init_gnt_early: got %0b want 0", gnt_early); else n_pass++;
    wait_done(0, cyc, wr, fg);
    req0 = 1'b0;
    n_checks++;
    if (cyc !== 4 || fg !== 1) $display("FAIL init_pending_req: got cyc=%0d gnt_at=%0d want 4 1", cyc, fg);
    else n_pass++;
    n_checks++;
    if (rdata0 !== 1'b0) $display("FAIL init_read0: got %0b want 0", rdata0); else n_pass++;
    for (int a = 1; a < 4; a++) begin
      @(negedge clk);
      issue(0, 1'b0, a[1:0], 1'b0);
      wait_done(0, cyc, wr, fg);
      req0 = 1'b0;
      n_checks++;
      if (rdata0 !== 1'b0) $display("FAIL init_read: addr %0d got %0b want 0", a, rdata0); else n_pass++;
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_write_read();
    int cyc, wr, fg;
    issue(0, 1'b1, 2'd2, 1'b1);
    wait_done(0, cyc, wr, fg);
    req0 = 1'b0;
    n_checks++;
    if (cyc !== 4) $display("FAIL write_latency: got %0d want 4", cyc); else n_pass++;
    n_checks++;
    if (wr !== 1) $display("FAIL write_strobe_count: got %0d want 1", wr); else n_pass++;
    n_checks++;
    if (fg !== 1) $display("FAIL write_gnt_start: got %0d want 1", fg); else n_pass++;
    @(negedge clk);
    issue(0, 1'b0, 2'd2, 1'b0);
    wait_done(0, cyc, wr, fg);
    req0 = 1'b0;
    n_checks++;
    if (cyc !== 4) $display("FAIL read_latency: got %0d want 4", cyc); else n_pass++;
    n_checks++;
    if (wr !== 0) $display("FAIL read_strobe_count: got %0d want 0", wr); else n_pass++;
    n_checks++;
    if (rdata0 !== 1'b1) $display("FAIL read_data: got %0b want 1", rdata0); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_tie();
    int who, n;
    do_reset();
    issue(0, 1'b1, 2'd0, 1'b1);
    issue(1, 1'b1, 2'd3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      who = -1; n = 0;
      while (who < 0 && n < 40) begin
        @(negedge clk);
        n++;
        if (done0) who = 0;
        else if (done1) who = 1;
      end
      n_checks++;
      if (who !== (k % 2)) $display("FAIL tie_order: step %0d got port %0d want %0d", k, who, k % 2);
      else n_pass++;
      if (who == 0) begin
        if (k < 2) issue(0, 1'b0, 2'd0, 1'b0); else req0 = 1'b0;
      end else if (who == 1) begin
        if (k < 2) issue(1, 1'b0, 2'd3, 1'b0); else req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_checks++;
    if ({rdata1, rdata0} !== 2'b11) $display("FAIL tie_rdata: got %b want 11", {rdata1, rdata0});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_request_during_busy();
    int n, cyc, wr, fg;
    issue(0, 1'b1, 2'd0, 1'b0);
    n = 0;
    while (!ram_wr && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== 2 || gnt0 !== 1'b1) $display("FAIL busy_strobe: got n=%0d gnt0=%0b want 2 1", n, gnt0);
    else n_pass++;
    issue(1, 1'b0, 2'd2, 1'b0);
    wait_done(0, cyc, wr, fg);
    req0 = 1'b0;
    n_checks++;
    if (cyc !== 2) $display("FAIL busy_done0: got %0d want 2", cyc); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1} !== 2'b00) $display("FAIL busy_idle_gap: got %b want 00", {gnt0, gnt1});
    else n_pass++;
    wait_done(1, cyc, wr, fg);
    req1 = 1'b0;
    n_checks++;
    if (cyc !== 4 || fg !== 1) $display("FAIL busy_done1: got cyc=%0d gnt_at=%0d want 4 1", cyc, fg);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_read_isolation();
    int cyc, wr, fg;
    issue(1, 1'b1, 2'd3, 1'b0);
    wait_done(1, cyc, wr, fg);
    req1 = 1'b0;
    n_checks++;
    if (cyc !== 4) $display("FAIL iso_write_latency: got %0d want 4", cyc); else n_pass++;
    @(negedge clk);
    issue(0, 1'b0, 2'd3, 1'b0);
    wait_done(0, cyc, wr, fg);
    req0 = 1'b0;
    n_checks++;
    if (rdata0 !== 1'b0) $display("FAIL iso_rdata0: got %0b want 0", rdata0); else n_pass++;
    n_checks++;
    if (rdata1 !== 1'b1) $display("FAIL iso_rdata1: got %0b want 1", rdata1); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_setup();
    int cyc, wr, fg;
    issue(0, 1'b1, 2'd1, 1'b1);
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1 || ram_wr !== 1'b0 || ram_a !== 2'd1)
      $display("FAIL rst_setup_state: got gnt0=%0b wr=%0b a=%0d want 1 0 1", gnt0, ram_wr, ram_a);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt0, gnt1, done0, done1, ram_wr, ram_rd, ram_din, rdata0, rdata1, ram_a} !== 11'b0)
      $display("FAIL rst_async_outputs: got %b want 0",
               {gnt0, gnt1, done0, done1, ram_wr, ram_rd, ram_din, rdata0, rdata1, ram_a});
    else n_pass++;
    n_checks++;
    if (init_busy !== EXP_INIT_BUSY) $display("FAIL rst_async_init_busy: got %0b want %0b", init_busy, EXP_INIT_BUSY);
    else n_pass++;
    n_checks++;
    if (mem[1] !== 1'b0) $display("FAIL rst_word1_kept: got %0b want 0", mem[1]); else n_pass++;
    do_reset();
    issue(0, 1'b0, 2'd1, 1'b0);
    wait_done(0, cyc, wr, fg);
    req0 = 1'b0;
    n_checks++;
    if (cyc !== 4 || rdata0 !== 1'b0) $display("FAIL rst_readback: got cyc=%0d rdata0=%0b want 4 0", cyc, rdata0);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 2'd0; addr1 = 2'd0; wdata0 = 1'b0; wdata1 = 1'b0;
    for (int i = 0; i < 4; i++) begin mem[i] = 1'b0; mdl[i] = 1'b0; end
    exp_rd = '0;
    test_reset();
`ifdef RAM_ARB_INIT_EN
    test_init();
`endif
    test_write_read();
    test_tie();
    test_request_during_busy();
    test_read_isolation();
    test_reset_setup();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Controller that shares the 4-word × 1-bit `ram` between two requesters and sequences every access. Each access follows a fixed write-strobe protocol, because the storage flip-flops capture on the falling edge of `wr`. The block sits between the `ram` instance and two client ports, such as a CPU-side port and a test or scrub port. Round-robin arbitration, one access in flight at a time.

## Interface
Parameters:
- ADDR_W, 2, RAM address width (4 words)
- DATA_W, 1, RAM word width

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request, held until matching done
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  word address; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- gnt0 / gnt1  out  1  requester owns the RAM (SETUP..DONE)
- done0 / done1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  last read result for that requester
- init_busy  out  1  power-up clear in progress
- ram_a  out  ADDR_W  to `ram` address
- ram_wr  out  1  to `ram` wr; write commits on its 1→0 transition
- ram_din  out  DATA_W  to `ram` Din
- ram_rd  out  1  to `ram` Rd
- ram_dout  in  DATA_W  from `ram` Dout (combinational read)

## Operation
- FSM states: INIT, IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: sample req0/req1.
  - Single request: granted.
  - Both requesting: grant the requester that was not served last.
  - Last-served pointer resets to 1, so req0 wins the first tie.
  - No request: stay in IDLE.
- On grant, register the winner's we/addr/wdata. ram_a and ram_din are driven from these registers, never from live inputs.
- SETUP: ram_wr=0, address/data settle, ram_rd=~we.
- STROBE: ram_wr=we, so the RAM is strobed only for writes.
- HOLD: ram_wr=0 (a falling edge commits the write). For reads, ram_dout is captured into the winner's rdata at the end of HOLD.
- DONE: winner's done=1 for exactly one cycle, gnt still high; then IDLE and the pointer is updated.
- The requester must drop req, or present a new access, after seeing done. A req still high in the cycle after DONE is treated as a new request.
- rdataN holds its value until the next read by that requester completes; writes do not change it.
- ram_a, ram_din and ram_rd stay stable from SETUP through HOLD.

## Timing
- Reset values:
  - State INIT if RAM_ARB_INIT_EN is defined, else IDLE.
  - gnt0/1=0, done0/1=0, rdata0/1=0, ram_wr=0, ram_rd=0, ram_a=0, ram_din=0, pointer=1.
  - init_busy=1 with the macro, else 0.
- Latency: req sampled high in IDLE at edge E0 → SETUP after E0 → STROBE after E1 → HOLD after E2 → DONE after E3 → IDLE after E4.
  - done is high in the cycle between E3 and E4.
  - Fixed 5-cycle access; back-to-back throughput is one access per 5 cycles.
- gnt is asserted from SETUP through DONE inclusive.
- A request arriving mid-access waits; it is never dropped.
- Reset asserted during STROBE forces ram_wr 1→0 together with ram_a→0. The contents of the addressed word and of word 0 are then undefined. Reset in any other state leaves RAM contents intact.

## Configuration
- RAM_ARB_INIT_EN defined: after reset release, the FSM clears all 4 words to 0.
  - Runs SETUP/STROBE/HOLD for addresses 0,1,2,3 in order: 12 cycles, no DONE pulses.
  - init_busy=1 throughout, then 0 on entry to IDLE.
  - Requests are held pending and granted afterwards.
- RAM_ARB_INIT_EN undefined: no INIT state, init_busy tied 0, RAM contents after power-up are whatever the flip-flops hold.

## Structure
- Package `ram_arb_pkg`:
  - State enum (INIT..DONE).
  - ADDR_W/DATA_W defaults.
  - NUM_WORDS = 4.
- Sub-module `rr_arbiter2`: combinational two-input round-robin pick from req0, req1 and the pointer, outputs one-hot grant. The pointer register lives in the top module.

## Test plan
- Write then read, no INIT macro: req0, we0=1, addr0=2, wdata0=1. ram_wr pulses high exactly one cycle (STROBE) and done0 pulses 4 cycles after sampling. Then req0, we0=0, addr0=2 → rdata0=1 at done0; ram_wr stays 0.
- Tie: req0 and req1 high in the same cycle after reset → gnt0 first. With both held, the next grant is gnt1, then gnt0 alternates.
- Request during busy: req1 rises while gnt0 is in STROBE → gnt1 asserts in the cycle after done0's IDLE cycle. done1 follows 4 cycles after its sampling.
- Read isolation: requester 1 writes 0 to addr 3, then requester 0 reads addr 3 → rdata0=0 and rdata1 unchanged.
- With RAM_ARB_INIT_EN, after pre-loading all words to 1:
  - Reset → init_busy high for 12 cycles, ram_a steps 0,1,2,3.
  - Subsequent reads of addresses 0..3 return 0.
  - A req0 raised during init is served after init_busy falls.
- Async reset during SETUP of a write to addr 1 → all outputs zero immediately, FSM in IDLE or INIT. Word 1 keeps its prior value, since no ram_wr edge occurred.
